// File: rtl/mips_exec_ctrl_pkg.sv
// Shared debug-side definitions for the MIPS execution controller:
// UART command bytes and controller state encoding.
package mips_exec_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        RUN    = 3'd3,
        STEP   = 3'd4,
        REPORT = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_EXIT = 8'h45;

endpackage

// File: rtl/mips_exec_ctrl_word_assembler.sv
// Packs incoming UART bytes MSB-first into an instruction word and flags
// the byte that completes it.
module word_assembler #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_done
);

    localparam int unsigned NBYTES = WORD_W / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              w_last;

    assign w_last    = (r_idx == IDX_W'(NBYTES - 1));
    assign word_done = byte_valid && !clr && w_last;
    assign word_out  = r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (byte_valid) begin
            r_word <= (r_word << BYTE_W) | WORD_W'(byte_in);
            r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mips_exec_ctrl.sv
// Debug-side sequencer for the MIPS core: program load over UART, free-run or
// single-step clock gating, cycle counting and cycle-count report on halt.
module mips_exec_ctrl
    import mips_exec_ctrl_pkg::*;
#(
    parameter int unsigned         NBIT_DATA_LEN = 8,
    parameter int unsigned         len_data      = 32,
    parameter int unsigned         len_addr      = 8,
    parameter int unsigned         CYCLE_CNT_W   = 32,
    parameter logic [len_data-1:0] HALT_WORD     = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
    input  logic                     tx_done_tick,
    output logic                     tx_start,
    output logic [NBIT_DATA_LEN-1:0] tx_data,
    input  logic                     halt,
    output logic                     ctrl_clk_mips,
    output logic                     debug,
    output logic                     wr_ram_inst,
    output logic [len_addr-1:0]      addr_mem_inst,
    output logic [len_data-1:0]      ins_to_mem,
    output logic                     busy
);

    localparam int unsigned TX_BYTES = CYCLE_CNT_W / NBIT_DATA_LEN;
    localparam int unsigned TXI_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

    state_t                   r_state, r_state_n;
    logic [len_addr-1:0]      r_addr;
    logic [CYCLE_CNT_W-1:0]   r_cnt;
    logic                     r_step_pulse;
    logic                     r_tx_start;
    logic [NBIT_DATA_LEN-1:0] r_tx_data;
    logic [TXI_W-1:0]         r_tx_idx;
    logic                     r_tx_wait;

    logic                     w_asm_clr, w_addr_clr, w_addr_inc, w_cnt_clr, w_pulse_set;
    logic                     w_report_enter, w_tx_send, w_tx_next;
    logic                     w_word_done, w_clk_en;
    logic [len_data-1:0]      w_word;
    logic [CYCLE_CNT_W-1:0]   w_cnt_shift;

    word_assembler #(
        .BYTE_W (NBIT_DATA_LEN),
        .WORD_W (len_data)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (w_asm_clr),
        .byte_valid (rx_done_tick && (r_state == LOAD)),
        .byte_in    (rx_data_in),
        .word_out   (w_word),
        .word_done  (w_word_done)
    );

    // Counter is frozen in REPORT, so the byte can be picked straight from it.
    assign w_cnt_shift   = r_cnt >> (NBIT_DATA_LEN * r_tx_idx);
    assign w_clk_en      = (r_state == RUN) || r_step_pulse;

    assign ctrl_clk_mips = w_clk_en;
    assign debug         = (r_state == STEP);
    assign wr_ram_inst   = (r_state == WRITE);
    assign busy          = (r_state != IDLE);
    assign addr_mem_inst = r_addr;
    assign ins_to_mem    = w_word;
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= r_state_n;
    end

    always_comb begin
        r_state_n      = r_state;
        w_asm_clr      = 1'b0;
        w_addr_clr     = 1'b0;
        w_addr_inc     = 1'b0;
        w_cnt_clr      = 1'b0;
        w_pulse_set    = 1'b0;
        w_report_enter = 1'b0;
        w_tx_send      = 1'b0;
        w_tx_next      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_done_tick) begin
                    if (rx_data_in == NBIT_DATA_LEN'(CMD_LOAD)) begin
                        r_state_n  = LOAD;
                        w_asm_clr  = 1'b1;
                        w_addr_clr = 1'b1;
                    end else if (rx_data_in == NBIT_DATA_LEN'(CMD_RUN) ||
                                 rx_data_in == NBIT_DATA_LEN'(CMD_STEP)) begin
                        w_cnt_clr = 1'b1;
                        if (halt) begin
                            r_state_n      = REPORT;
                            w_report_enter = 1'b1;
                        end else if (rx_data_in == NBIT_DATA_LEN'(CMD_RUN)) begin
                            r_state_n = RUN;
                        end else begin
                            // The entering 'S' also advances the core by one cycle.
                            r_state_n   = STEP;
                            w_pulse_set = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                if (w_word_done) r_state_n = WRITE;
            end
            WRITE: begin
                if (w_word == HALT_WORD || r_addr == '1) begin
                    r_state_n = IDLE;
                end else begin
                    r_state_n  = LOAD;
                    w_addr_inc = 1'b1;
                end
            end
            RUN: begin
                if (halt) begin
                    r_state_n      = REPORT;
                    w_report_enter = 1'b1;
                end
            end
            STEP: begin
                if (halt || (rx_done_tick && rx_data_in == NBIT_DATA_LEN'(CMD_EXIT))) begin
                    r_state_n      = REPORT;
                    w_report_enter = 1'b1;
                end else if (rx_done_tick && rx_data_in == NBIT_DATA_LEN'(CMD_STEP)) begin
                    w_pulse_set = 1'b1;
                end
            end
            REPORT: begin
                if (!r_tx_wait) begin
                    w_tx_send = 1'b1;
                end else if (tx_done_tick) begin
                    if (r_tx_idx == '0) r_state_n = IDLE;
                    else                w_tx_next = 1'b1;
                end
            end
            default: r_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_step_pulse <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_idx     <= '0;
            r_tx_wait    <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_step_pulse <= w_pulse_set;
            if (w_addr_clr)      r_addr <= '0;
            else if (w_addr_inc) r_addr <= r_addr + len_addr'(1);
            if (w_cnt_clr)                      r_cnt <= '0;
            else if (w_clk_en && r_cnt != '1)   r_cnt <= r_cnt + CYCLE_CNT_W'(1);
            if (w_report_enter) begin
                r_tx_idx  <= TXI_W'(TX_BYTES - 1);
                r_tx_wait <= 1'b0;
            end else if (w_tx_send) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= w_cnt_shift[NBIT_DATA_LEN-1:0];
                r_tx_wait  <= 1'b1;
            end else if (w_tx_next) begin
                r_tx_idx  <= r_tx_idx - TXI_W'(1);
                r_tx_wait <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Scoreboard bench for mips_exec_ctrl: RAM writes and TX bytes are checked
// by a negedge monitor against queues filled by the stimulus.
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done_tick;
    logic [7:0]  rx_data_in;
    logic        tx_done_tick;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        halt;
    logic        ctrl_clk_mips;
    logic        debug;
    logic        wr_ram_inst;
    logic [7:0]  addr_mem_inst;
    logic [31:0] ins_to_mem;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          en_cycles = 0;
    int          en_rises = 0;
    int          overlap = 0;
    logic        prev_en = 1'b0;

    always #5 clk = ~clk;

    mips_exec_ctrl #(
        .NBIT_DATA_LEN (8),
        .len_data      (32),
        .len_addr      (8),
        .CYCLE_CNT_W   (32),
        .HALT_WORD     (32'hFFFFFFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_done_tick  (rx_done_tick),
        .rx_data_in    (rx_data_in),
        .tx_done_tick  (tx_done_tick),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .halt          (halt),
        .ctrl_clk_mips (ctrl_clk_mips),
        .debug         (debug),
        .wr_ram_inst   (wr_ram_inst),
        .addr_mem_inst (addr_mem_inst),
        .ins_to_mem    (ins_to_mem),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a TX byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_ram_inst) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got %0h_%0h want none", addr_mem_inst, ins_to_mem);
                end else begin
                    chk("wr_addr_word", 64'({addr_mem_inst, ins_to_mem}), 64'(exp_wr.pop_front()));
                end
            end
            if (tx_start) begin
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got %0h want none", tx_data);
                end else begin
                    chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                end
            end
            if (ctrl_clk_mips) en_cycles++;
            if (ctrl_clk_mips && !prev_en) en_rises++;
            if (ctrl_clk_mips && wr_ram_inst) overlap++;
            prev_en = ctrl_clk_mips;
        end
    end

    // UART transmitter model: finishes each byte a few cycles after tx_start.
    initial begin
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                repeat (3) @(posedge clk);
                #1 tx_done_tick = 1'b1;
                @(posedge clk);
                #1 tx_done_tick = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data_in   = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic push_count(input logic [31:0] c);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(c >> (8 * i)));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, 64'(busy), 64'(0));
    endtask

    initial begin
        int en0;
        int r0;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data_in   = 8'h00;
        halt         = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ctrl", 64'(ctrl_clk_mips), 64'(0));
        chk("rst_wr", 64'(wr_ram_inst), 64'(0));
        chk("rst_tx_start", 64'(tx_start), 64'(0));

        // 1: load two words, the second is the terminator
        exp_wr.push_back({8'h00, 32'h00000001});
        exp_wr.push_back({8'h01, 32'hFFFFFFFF});
        send_byte(8'h4C);
        chk("t1_busy_load", 64'(busy), 64'(1));
        send_word(32'h00000001);
        send_word(32'hFFFFFFFF);
        wait_idle("t1_idle");
        chk("t1_addr_end", 64'(addr_mem_inst), 64'(8'h01));
        chk("t1_wr_drained", 64'(exp_wr.size()), 64'(0));

        // 2: free run, halt during the 10th enabled cycle
        push_count(32'd10);
        en0 = en_cycles;
        send_byte(8'h52);
        repeat (9) @(posedge clk);
        #1 halt = 1'b1;
        @(posedge clk); #1;
        chk("t2_ctrl_off", 64'(ctrl_clk_mips), 64'(0));
        chk("t2_en_cycles", 64'(en_cycles - en0), 64'(10));
        chk("t2_busy_report", 64'(busy), 64'(1));
        wait_idle("t2_idle");
        halt = 1'b0;
        chk("t2_tx_drained", 64'(exp_tx.size()), 64'(0));

        // 3: step three times then exit
        push_count(32'd3);
        en0 = en_cycles;
        r0  = en_rises;
        send_byte(8'h53);
        chk("t3_debug1", 64'(debug), 64'(1));
        send_byte(8'h53);
        chk("t3_debug2", 64'(debug), 64'(1));
        send_byte(8'h53);
        chk("t3_debug3", 64'(debug), 64'(1));
        send_byte(8'h45);
        chk("t3_debug_exit", 64'(debug), 64'(0));
        wait_idle("t3_idle");
        chk("t3_en_cycles", 64'(en_cycles - en0), 64'(3));
        chk("t3_en_pulses", 64'(en_rises - r0), 64'(3));
        chk("t3_tx_drained", 64'(exp_tx.size()), 64'(0));

        // 4: halt already pending when 'R' arrives
        halt = 1'b1;
        push_count(32'd0);
        en0 = en_cycles;
        send_byte(8'h52);
        chk("t4_busy", 64'(busy), 64'(1));
        wait_idle("t4_idle");
        halt = 1'b0;
        chk("t4_no_clk", 64'(en_cycles - en0), 64'(0));
        chk("t4_tx_drained", 64'(exp_tx.size()), 64'(0));

        // 5: reset after two load bytes, then a fresh load starts at address 0
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_ins", 64'(ins_to_mem), 64'(0));
        chk("t5_addr", 64'(addr_mem_inst), 64'(0));
        chk("t5_debug", 64'(debug), 64'(0));
        chk("t5_tx_data", 64'(tx_data), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        exp_wr.push_back({8'h00, 32'h11223344});
        exp_wr.push_back({8'h01, 32'hFFFFFFFF});
        send_byte(8'h4C);
        send_word(32'h11223344);
        send_word(32'hFFFFFFFF);
        wait_idle("t5_idle");
        chk("t5_wr_drained", 64'(exp_wr.size()), 64'(0));

        // 6: fill the whole RAM with non-terminator words; load ends at 8'hFF
        send_byte(8'h4C);
        for (int i = 0; i < 256; i++) begin
            exp_wr.push_back({8'(i), 32'(i) + 32'h00010000});
            send_word(32'(i) + 32'h00010000);
        end
        wait_idle("t6_idle_after_wrap");
        chk("t6_addr_end", 64'(addr_mem_inst), 64'(8'hFF));
        chk("t6_wr_drained", 64'(exp_wr.size()), 64'(0));
        halt = 1'b1;
        push_count(32'd0);
        send_byte(8'h52);
        send_byte(8'h52);
        chk("t6_busy_report", 64'(busy), 64'(1));
        wait_idle("t6_idle_after_report");
        halt = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_still_idle", 64'(busy), 64'(0));
        chk("t6_tx_drained", 64'(exp_tx.size()), 64'(0));

        chk("no_wr_clk_overlap", 64'(overlap), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
